// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing a byte register bank with an auto-incrementing
// pointer, plus a parallel host port onto the same bank.
module i2c_target_regs #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h42,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      io_mainClk,
  input  logic                      io_asyncResetn,
  input  logic                      io_i2c_scl_read,
  output logic                      io_i2c_scl_write,
  input  logic                      io_i2c_sda_read,
  output logic                      io_i2c_sda_write,
  input  logic [REG_ADDR_WIDTH-1:0] io_regs_addr,
  input  logic                      io_regs_writeEnable,
  input  logic [7:0]                io_regs_writeData,
  output logic [7:0]                io_regs_readData,
  output logic                      io_writeStrobe,
  output logic [REG_ADDR_WIDTH-1:0] io_writeAddr,
  output logic                      io_busy
);
  localparam int AW = REG_ADDR_WIDTH;
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, WR_PTR, WR_ACK, WR_DATA, RD_DATA, RD_ACK, IGNORE} state_t;
  state_t state, state_n;
  logic scl_m, scl_s, scl_d, sda_m, sda_s, sda_d;
  logic scl_rise, scl_fall, start, stop, match, commit;
  logic sda_n, busy_n, rw, rw_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, byte_in;
  logic [AW-1:0] ptr, ptr_n;
  logic [7:0] regs [2**AW];

  assign io_i2c_scl_write = 1'b1;
  assign io_regs_readData = regs[io_regs_addr];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start = scl_s & scl_d & sda_d & ~sda_s;
  assign stop = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_in = {sh[6:0], sda_s};
  assign match = sh[7:1] == DEVICE_ADDRESS;

  always_ff @(posedge io_mainClk or negedge io_asyncResetn)
    if (!io_asyncResetn) {scl_m, scl_s, scl_d, sda_m, sda_s, sda_d} <= '1;
    else {scl_m, scl_s, scl_d, sda_m, sda_s, sda_d} <= {io_i2c_scl_read, scl_m, scl_s, io_i2c_sda_read, sda_m, sda_s};

  always_ff @(posedge io_mainClk or negedge io_asyncResetn)
    if (!io_asyncResetn) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      ptr <= '0;
      rw <= 1'b0;
      io_i2c_sda_write <= 1'b1;
      io_busy <= 1'b0;
      io_writeStrobe <= 1'b0;
      io_writeAddr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      ptr <= ptr_n;
      rw <= rw_n;
      io_i2c_sda_write <= sda_n;
      io_busy <= busy_n;
      io_writeStrobe <= commit;
      if (commit) io_writeAddr <= ptr;
    end

  // I2C commit is assigned last so it wins a same-address collision with the host
  always_ff @(posedge io_mainClk or negedge io_asyncResetn)
    if (!io_asyncResetn) begin
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
    end else begin
      if (io_regs_writeEnable) regs[io_regs_addr] <= io_regs_writeData;
      if (commit) regs[ptr] <= byte_in;
    end

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    ptr_n = ptr;
    rw_n = rw;
    sda_n = io_i2c_sda_write;
    busy_n = io_busy;
    commit = 1'b0;
    if (start) begin
      state_n = ADDR;
      cnt_n = '0;
      sda_n = 1'b1;
    end else if (stop) begin
      state_n = IDLE;
      sda_n = 1'b1;
      busy_n = 1'b0;
    end else begin
      case (state)
        ADDR, WR_PTR, WR_DATA:
          if (scl_rise && cnt != 4'd8) begin
            sh_n = byte_in;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7 && state == WR_PTR) ptr_n = byte_in[AW-1:0];
            if (cnt == 4'd7 && state == WR_DATA) begin
              commit = 1'b1;
              ptr_n = ptr + AW'(1);
            end
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = state != ADDR ? WR_ACK : match ? ADDR_ACK : IGNORE;
            sda_n = state == ADDR && !match;
            busy_n = io_busy | (state == ADDR && match);
            rw_n = state == ADDR ? sh[0] : rw;
          end
        ADDR_ACK:
          if (scl_fall) begin
            state_n = rw ? RD_DATA : WR_PTR;
            sda_n = rw ? regs[ptr][7] : 1'b1;
            sh_n = {regs[ptr][6:0], 1'b0};
            cnt_n = rw ? 4'd1 : 4'd0;
            ptr_n = rw ? ptr + AW'(1) : ptr;
          end
        WR_ACK:
          if (scl_fall) begin
            state_n = WR_DATA;
            sda_n = 1'b1;
            cnt_n = '0;
          end
        // cnt counts bits already presented; the fall after the 8th hands SDA back for the ACK
        RD_DATA:
          if (scl_fall) begin
            state_n = cnt == 4'd8 ? RD_ACK : RD_DATA;
            sda_n = cnt == 4'd8 ? 1'b1 : sh[7];
            sh_n = {sh[6:0], 1'b0};
            cnt_n = cnt + 4'd1;
          end
        RD_ACK:
          if (scl_rise) begin
            state_n = sda_s ? IGNORE : RD_DATA;
            busy_n = !sda_s && io_busy;
            sh_n = regs[ptr];
            cnt_n = '0;
            ptr_n = sda_s ? ptr : ptr + AW'(1);
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C master plus host port, checked against a byte-array model.
module tb_i2c_target_regs;
  logic clk = 1'b0, rst_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1, we = 1'b0;
  logic scl_w, sda_w, strobe, busy, scl_bus, sda_bus;
  logic [3:0] haddr = '0, waddr;
  logic [7:0] hdata = '0, rdata;
  int checks = 0, errors = 0, sda_low = 0;
  logic [3:0] qa[$];
  logic [7:0] mregs [16];
  int mptr = 0;

  assign scl_bus = m_scl & scl_w;
  assign sda_bus = m_sda & sda_w;

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .io_mainClk(clk), .io_asyncResetn(rst_n),
    .io_i2c_scl_read(scl_bus), .io_i2c_scl_write(scl_w),
    .io_i2c_sda_read(sda_bus), .io_i2c_sda_write(sda_w),
    .io_regs_addr(haddr), .io_regs_writeEnable(we), .io_regs_writeData(hdata),
    .io_regs_readData(rdata), .io_writeStrobe(strobe), .io_writeAddr(waddr), .io_busy(busy)
  );

  always @(negedge clk) begin
    if (strobe) qa.push_back(waddr);
    if (!sda_w) sda_low++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one SCL period; optional host write lands on the same clock edge as an 8th-bit commit
  task automatic tick(input logic b, input logic hw, input logic [3:0] ha, input logic [7:0] hd, output logic s);
    w(8);
    m_sda = b;
    w(8);
    m_scl = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      w(1);
      if (hw && i == 2) begin
        we = 1'b1;
        haddr = ha;
        hdata = hd;
      end
      if (i == 3) we = 1'b0;
      if (i == 8) s = sda_bus;
    end
    m_scl = 1'b0;
  endtask

  task automatic start();
    w(8);
    m_sda = 1'b1;
    w(8);
    m_scl = 1'b1;
    w(16);
    m_sda = 1'b0;
    w(16);
    m_scl = 1'b0;
  endtask

  task automatic stop();
    w(8);
    m_sda = 1'b0;
    w(8);
    m_scl = 1'b1;
    w(16);
    m_sda = 1'b1;
    w(16);
  endtask

  task automatic wbyte_h(input logic [7:0] b, input logic hw, input logic [3:0] ha, input logic [7:0] hd, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) tick(b[i], hw && i == 0, ha, hd, s);
    tick(1'b1, 1'b0, 4'd0, 8'd0, ack);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    wbyte_h(b, 1'b0, 4'd0, 8'd0, ack);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      tick(1'b1, 1'b0, 4'd0, 8'd0, s);
      b[i] = s;
    end
    tick(nack, 1'b0, 4'd0, 8'd0, s);
  endtask

  task automatic hwrite(input logic [3:0] a, input logic [7:0] d);
    haddr = a;
    hdata = d;
    we = 1'b1;
    w(1);
    we = 1'b0;
  endtask

  task automatic hread(input logic [3:0] a, output logic [7:0] d);
    haddr = a;
    w(1);
    d = rdata;
  endtask

  initial begin
    logic ack, s;
    logic [7:0] d8;
    int base, op, k, p, d, a;
    int exp_a[3];
    foreach (mregs[i]) mregs[i] = '0;
    w(3);
    check("rst_sda", 32'(sda_w), 1);
    check("rst_scl", 32'(scl_w), 1);
    check("rst_strobe", 32'(strobe), 0);
    check("rst_busy", 32'(busy), 0);
    hread(4'd15, d8);
    check("rst_reg15", 32'(d8), 0);
    rst_n = 1'b1;
    w(4);

    // basic write: ptr 3, two bytes
    base = qa.size();
    start();
    wbyte(8'h84, ack);
    check("wr_addr_ack", 32'(ack), 0);
    check("wr_busy_mid", 32'(busy), 1);
    wbyte(8'h03, ack);
    check("wr_ptr_ack", 32'(ack), 0);
    mptr = 3;
    wbyte(8'hA5, ack);
    check("wr_d0_ack", 32'(ack), 0);
    mregs[mptr] = 'hA5;
    mptr = (mptr + 1) % 16;
    wbyte(8'h5A, ack);
    check("wr_d1_ack", 32'(ack), 0);
    mregs[mptr] = 'h5A;
    mptr = (mptr + 1) % 16;
    stop();
    check("wr_busy_after", 32'(busy), 0);
    check("wr_strobe_cnt", 32'(qa.size() - base), 2);
    check("wr_strobe_a0", 32'(qa[base]), 3);
    check("wr_strobe_a1", 32'(qa[base+1]), 4);
    hread(4'd3, d8);
    check("wr_reg3", 32'(d8), 32'(mregs[3]));
    hread(4'd4, d8);
    check("wr_reg4", 32'(d8), 32'(mregs[4]));

    // read across the wrap with a repeated START
    hwrite(4'd15, 8'h11);
    mregs[15] = 'h11;
    hwrite(4'd0, 8'h22);
    mregs[0] = 'h22;
    start();
    wbyte(8'h84, ack);
    wbyte(8'h0F, ack);
    mptr = 15;
    start();
    wbyte(8'h85, ack);
    check("rd_addr_ack", 32'(ack), 0);
    rbyte(1'b0, d8);
    check("rd_b0", 32'(d8), 32'(mregs[mptr]));
    mptr = (mptr + 1) % 16;
    rbyte(1'b1, d8);
    check("rd_b1", 32'(d8), 32'(mregs[mptr]));
    mptr = (mptr + 1) % 16;
    check("rd_busy_nack", 32'(busy), 0);
    stop();
    hwrite(4'd1, 8'h77);
    mregs[1] = 'h77;
    start();
    wbyte(8'h85, ack);
    rbyte(1'b1, d8);
    check("rd_ptr_persist", 32'(d8), 32'(mregs[mptr]));
    mptr = (mptr + 1) % 16;
    stop();

    // address mismatch
    base = qa.size();
    a = sda_low;
    start();
    wbyte(8'h86, ack);
    check("mm_nack", 32'(ack), 1);
    check("mm_sda_low", 32'(sda_low - a), 0);
    check("mm_busy", 32'(busy), 0);
    stop();
    check("mm_strobe", 32'(qa.size() - base), 0);

    // abort after four data bits, then a clean write
    base = qa.size();
    start();
    wbyte(8'h84, ack);
    wbyte(8'h06, ack);
    mptr = 6;
    tick(1'b1, 1'b0, 4'd0, 8'd0, s);
    tick(1'b0, 1'b0, 4'd0, 8'd0, s);
    tick(1'b1, 1'b0, 4'd0, 8'd0, s);
    tick(1'b0, 1'b0, 4'd0, 8'd0, s);
    stop();
    hread(4'd6, d8);
    check("ab_reg6", 32'(d8), 32'(mregs[6]));
    check("ab_strobe", 32'(qa.size() - base), 0);
    check("ab_sda", 32'(sda_w), 1);
    check("ab_busy", 32'(busy), 0);
    start();
    wbyte(8'h84, ack);
    wbyte(8'h06, ack);
    mptr = 6;
    wbyte(8'hC3, ack);
    check("ab_retry_ack", 32'(ack), 0);
    mregs[mptr] = 'hC3;
    mptr = (mptr + 1) % 16;
    stop();
    hread(4'd6, d8);
    check("ab_retry_reg6", 32'(d8), 32'(mregs[6]));

    // host/I2C collisions: same address, then different address
    base = qa.size();
    start();
    wbyte(8'h84, ack);
    wbyte(8'h02, ack);
    mptr = 2;
    wbyte_h(8'h33, 1'b1, 4'd2, 8'hFF, ack);
    mregs[2] = 'h33;
    wbyte_h(8'h44, 1'b1, 4'd9, 8'h99, ack);
    mregs[3] = 'h44;
    mregs[9] = 'h99;
    mptr = 4;
    stop();
    check("col_strobe_a0", 32'(qa[base]), 2);
    hread(4'd2, d8);
    check("col_reg2", 32'(d8), 32'(mregs[2]));
    hread(4'd3, d8);
    check("col_reg3", 32'(d8), 32'(mregs[3]));
    hread(4'd9, d8);
    check("col_reg9", 32'(d8), 32'(mregs[9]));

    // randomized transactions against the model
    for (int n = 0; n < 12; n++) begin
      op = $urandom_range(0, 2);
      k = $urandom_range(1, 3);
      if (op == 0) begin
        a = $urandom_range(0, 15);
        d = $urandom_range(0, 255);
        hwrite(4'(a), 8'(d));
        mregs[a] = 8'(d);
      end else if (op == 1) begin
        base = qa.size();
        p = $urandom_range(0, 255);
        start();
        wbyte(8'h84, ack);
        check("rnd_wa_ack", 32'(ack), 0);
        wbyte(8'(p), ack);
        check("rnd_wp_ack", 32'(ack), 0);
        mptr = p % 16;
        for (int j = 0; j < k; j++) begin
          d = $urandom_range(0, 255);
          wbyte(8'(d), ack);
          check("rnd_wd_ack", 32'(ack), 0);
          exp_a[j] = mptr;
          mregs[mptr] = 8'(d);
          mptr = (mptr + 1) % 16;
        end
        stop();
        check("rnd_strobe_cnt", 32'(qa.size() - base), 32'(k));
        for (int j = 0; j < k && base + j < qa.size(); j++) check("rnd_strobe_a", 32'(qa[base+j]), 32'(exp_a[j]));
      end else begin
        start();
        if ($urandom_range(0, 1) == 1) begin
          p = $urandom_range(0, 255);
          wbyte(8'h84, ack);
          wbyte(8'(p), ack);
          mptr = p % 16;
          start();
        end
        wbyte(8'h85, ack);
        check("rnd_ra_ack", 32'(ack), 0);
        for (int j = 0; j < k; j++) begin
          rbyte(j == k - 1, d8);
          check("rnd_rd", 32'(d8), 32'(mregs[mptr]));
          mptr = (mptr + 1) % 16;
        end
        stop();
      end
    end
    for (int i = 0; i < 16; i++) begin
      hread(4'(i), d8);
      check("rnd_bank", 32'(d8), 32'(mregs[i]));
    end

    // asynchronous reset while the address ACK pulls SDA low
    start();
    for (int i = 7; i >= 0; i--) tick(1'(8'h84 >> i), 1'b0, 4'd0, 8'd0, s);
    for (int i = 0; i < 16 && sda_w; i++) w(1);
    check("rs_ack_drive", 32'(sda_w), 0);
    haddr = 4'd9;
    w(1);
    rst_n = 1'b0;
    #1;
    check("rs_sda", 32'(sda_w), 1);
    check("rs_busy", 32'(busy), 0);
    check("rs_reg9", 32'(rdata), 0);
    foreach (mregs[i]) mregs[i] = '0;
    mptr = 0;
    w(2);
    rst_n = 1'b1;
    w(8);
    start();
    wbyte(8'h84, ack);
    check("rs_fresh_ack", 32'(ack), 0);
    wbyte(8'h0A, ack);
    mptr = 10;
    wbyte(8'h3C, ack);
    mregs[mptr] = 'h3C;
    stop();
    hread(4'd10, d8);
    check("rs_fresh_reg10", 32'(d8), 32'(mregs[10]));
    hread(4'd3, d8);
    check("rs_reg3_clear", 32'(d8), 32'(mregs[3]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
